// File: rtl/wb_regbank_pkg.sv
// Shared constants and types for the wb_regbank Wishbone register bank.
package wb_regbank_pkg;

    localparam logic [31:0] ID_VALUE    = 32'h4669626f;
    localparam logic [7:0]  VERSION     = 8'h02;
    localparam logic [31:0] SCRATCH_RST = 32'hf00df00d;
    localparam logic [31:0] WINDOW_SIZE = 32'h00000080;

    localparam logic [6:0] OFF_ID       = 7'h00;
    localparam logic [6:0] OFF_PARAMS   = 7'h04;
    localparam logic [6:0] OFF_IRQ_EN   = 7'h08;
    localparam logic [6:0] OFF_IRQ_STAT = 7'h0C;
    localparam logic [6:0] OFF_SCRATCH  = 7'h10;
    localparam logic [6:0] OFF_PANIC    = 7'h14;
    localparam logic [6:0] OFF_CH_CTRL0 = 7'h20;
    localparam logic [6:0] OFF_CH_VAL0  = 7'h24;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_ACK  = 1'b1
    } bus_state_e;

    typedef struct packed {
        logic        cyc;
        logic        stb;
        logic        we;
        logic [3:0]  sel;
        logic [31:0] adr;
        logic [31:0] dat;
    } wb_req_t;

endpackage

// File: rtl/wb_regbank_irq.sv
// Interrupt block: rising-edge detect, sticky status with write-1-to-clear, enable mask.
module wb_regbank_irq #(
    parameter int unsigned N = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] src,
    input  logic [N-1:0] en,
    input  logic [N-1:0] clr,
    output logic [N-1:0] stat_q,
    output logic [N-1:0] irq_c
);

    logic [N-1:0] prev_q;

    // A new edge beats a simultaneous clear.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            prev_q <= src;
            stat_q <= '0;
        end else begin
            prev_q <= src;
            stat_q <= (stat_q & ~clr) | (src & ~prev_q);
        end
    end

    assign irq_c = stat_q & en;

endmodule

// File: rtl/wb_regbank.sv
// Wishbone classic register bank: ID/params, IRQ control, scratch/panic, per-channel control and value.
module wb_regbank
    import wb_regbank_pkg::*;
#(
    parameter logic [31:0] BASE_ADDRESS = 32'h30000000,
    parameter int unsigned NUM_CH       = 2,
    parameter int unsigned CLOCK_WIDTH  = 6,
    parameter int unsigned VAL_WIDTH    = 30,
    parameter int unsigned NUM_IRQ      = 3
) (
    input  logic                          wb_clk_i,
    input  logic                          wb_rst_ni,
    input  logic                          wbs_stb_i,
    input  logic                          wbs_cyc_i,
    input  logic                          wbs_we_i,
    input  logic [3:0]                    wbs_sel_i,
    input  logic [31:0]                   wbs_adr_i,
    input  logic [31:0]                   wbs_dat_i,
    output logic                          wbs_ack_o,
    output logic [31:0]                   wbs_dat_o,
    input  logic [NUM_CH*VAL_WIDTH-1:0]   ch_val_i,
    input  logic [NUM_IRQ-1:0]            irq_src_i,
    output logic [NUM_CH-1:0]             switch_out,
    output logic [NUM_CH*CLOCK_WIDTH-1:0] clock_sel_out,
    output logic [NUM_IRQ-1:0]            irq_out
);

    localparam int unsigned CW = CLOCK_WIDTH;

    wb_req_t    bus;
    bus_state_e state_q, state_d;
    logic [31:0] off;
    logic [4:0]  word;
    logic        in_window, req, capture, wr;
    logic [31:0] rdata;
    logic        unused_off;

    logic [NUM_IRQ-1:0]      irq_en_q, irq_stat, irq_clr, irq_c;
    logic [31:0]             scratch_q;
    logic                    panic_q;
    logic [NUM_CH-1:0]       ch_en_q;
    logic [NUM_CH*CW-1:0]    ch_clk_q;

    assign bus = '{cyc: wbs_cyc_i, stb: wbs_stb_i, we: wbs_we_i,
                   sel: wbs_sel_i, adr: wbs_adr_i, dat: wbs_dat_i};

    // Address decode; offsets are word-granular within the 128-byte window.
    assign off        = bus.adr - BASE_ADDRESS;
    assign word       = off[6:2];
    assign unused_off = ^{off[31:7], off[1:0]};
    assign in_window  = (bus.adr >= BASE_ADDRESS) && (off < WINDOW_SIZE);
    assign req        = bus.stb && bus.cyc && in_window;
    assign capture    = (state_q == ST_IDLE) && req;
    assign wr         = capture && bus.we;

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_ni) state_q <= ST_IDLE;
        else            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (req) state_d = ST_ACK;
            ST_ACK:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        rdata = '0;
        case (word)
            OFF_ID[6:2]:       rdata = ID_VALUE;
            OFF_PARAMS[6:2]:   rdata = {VERSION, 8'(NUM_IRQ), 4'(CLOCK_WIDTH), 4'(NUM_CH), 8'(VAL_WIDTH)};
            OFF_IRQ_EN[6:2]:   rdata = 32'(irq_en_q);
            OFF_IRQ_STAT[6:2]: rdata = 32'(irq_stat);
            OFF_SCRATCH[6:2]:  rdata = scratch_q;
            OFF_PANIC[6:2]:    rdata = 32'(panic_q);
            default: begin
                for (int unsigned n = 0; n < NUM_CH; n++) begin
                    if (word == 5'(OFF_CH_CTRL0[6:2] + 2 * n))
                        rdata = 32'({ch_clk_q[n*CW +: CW], ch_en_q[n]});
                    if (word == 5'(OFF_CH_VAL0[6:2] + 2 * n))
                        rdata = 32'(ch_val_i[n*VAL_WIDTH +: VAL_WIDTH]);
                end
            end
        endcase
    end

    // Response registers: read data lives only for the single ACK cycle.
    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_ni) begin
            wbs_ack_o <= 1'b0;
            wbs_dat_o <= '0;
        end else begin
            wbs_ack_o <= (state_d == ST_ACK);
            wbs_dat_o <= (capture && !bus.we) ? rdata : '0;
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_ni) begin
            irq_en_q  <= '0;
            scratch_q <= SCRATCH_RST;
            panic_q   <= 1'b0;
            ch_en_q   <= '1;
            ch_clk_q  <= {NUM_CH{CW'(1)}};
        end else if (wr) begin
            case (word)
                OFF_IRQ_EN[6:2]: if (bus.sel[0]) irq_en_q <= bus.dat[NUM_IRQ-1:0];
                OFF_SCRATCH[6:2]: begin
                    for (int unsigned k = 0; k < 4; k++)
                        if (bus.sel[k]) scratch_q[8*k +: 8] <= bus.dat[8*k +: 8];
                end
                OFF_PANIC[6:2]: begin
                    panic_q   <= 1'b1;
                    scratch_q <= bus.dat;
                end
                default: begin
                    for (int unsigned n = 0; n < NUM_CH; n++) begin
                        if (bus.sel[0] && word == 5'(OFF_CH_CTRL0[6:2] + 2 * n)) begin
                            ch_en_q[n]          <= bus.dat[0];
                            ch_clk_q[n*CW +: CW] <= bus.dat[CW:1];
                        end
                    end
                end
            endcase
        end
    end

    assign irq_clr = (wr && word == OFF_IRQ_STAT[6:2] && bus.sel[0]) ? bus.dat[NUM_IRQ-1:0] : '0;

    wb_regbank_irq #(.N(NUM_IRQ)) u_irq (
        .clk    (wb_clk_i),
        .rst_n  (wb_rst_ni),
        .src    (irq_src_i),
        .en     (irq_en_q),
        .clr    (irq_clr),
        .stat_q (irq_stat),
        .irq_c  (irq_c)
    );

    // Outputs are held low for the whole reset period.
    assign switch_out    = wb_rst_ni ? ch_en_q  : '0;
    assign clock_sel_out = wb_rst_ni ? ch_clk_q : '0;
    assign irq_out       = wb_rst_ni ? irq_c    : '0;

endmodule
